gpio32_edge_irq_wb: RTL and testbench

//  Pad-side input stage that sits directly upstream of the 32-bit GPIO controller's gpio_in port.
//  - Synchronises 32 asynchronous pad inputs and forwards the clean copy on gpio_in_sync.
//  - Detects per-bit rising/falling edges and latches them in a sticky status register.
//  - Raises a single level interrupt (irq) for masked status bits.
//  - Register access is through its own Wishbone slave on the same bus and clock.

---
 rtl/gpio32_edge_irq_wb_pkg.sv | 23 ++
 rtl/gpio32_edge_irq_wb_sync.sv | 25 ++
 rtl/gpio32_edge_irq_wb.sv | 109 ++++++++++
 tb/tb_gpio32_edge_irq_wb.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/gpio32_edge_irq_wb_pkg.sv
// Shared register map, default synchroniser depth and byte-lane helper for the
// GPIO pad-side edge/interrupt block.
package gpio32_edge_irq_wb_pkg;

  localparam int SYNC_STAGES_DEF = 2;

  localparam logic [7:0] IRQ_SYNC   = 8'h00;
  localparam logic [7:0] IRQ_RISE   = 8'h04;
  localparam logic [7:0] IRQ_FALL   = 8'h08;
  localparam logic [7:0] IRQ_STATUS = 8'h0c;
  localparam logic [7:0] IRQ_MASK   = 8'h10;

  // Expand the four Wishbone byte selects into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{sel[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio32_edge_irq_wb_sync.sv
// Plain WIDTH-bit flop-chain synchroniser, STAGES deep, cleared by reset.
module gpio_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_p [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage_p[i] <= '0;
    end else begin
      stage_p[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_p[i] <= stage_p[i-1];
    end
  end

  assign q = stage_p[STAGES-1];

endmodule

// File: rtl/gpio32_edge_irq_wb.sv
// Pad input stage: synchronises 32 pads, latches enabled edges into sticky
// status and raises a masked level interrupt; configured over Wishbone.
module gpio32_edge_irq_wb
  import gpio32_edge_irq_wb_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_dat_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic [31:0] pad_in,
  output logic [31:0] gpio_in_sync,
  output logic        irq
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_INIT = ARM_W'(SYNC_STAGES + 1);

  logic [31:0] prev_p1;
  logic [31:0] rise_en, fall_en, status, mask;
  logic [ARM_W-1:0] arm_cnt;

  logic        valid, access, wr;
  logic [7:0]  adr;
  logic [31:0] bmask, w1c, rise, fall, rdata;
  logic        unused_adr;

  assign unused_adr = ^wb_adr_i[31:8];

  gpio_sync #(
    .WIDTH  (32),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (pad_in),
    .q   (gpio_in_sync)
  );

  always_comb begin
    valid  = wb_cyc_i & wb_stb_i;
    access = valid & ~wb_ack_o;
    wr     = access & wb_we_i;
    adr    = wb_adr_i[7:0];
    bmask  = lane_mask(wb_sel_i);
    w1c    = (wr && adr == IRQ_STATUS) ? (wb_dat_i & bmask) : '0;
    // Edges are held off until the synchroniser and prev hold settled pad data.
    if (arm_cnt != '0) begin
      rise = '0;
      fall = '0;
    end else begin
      rise = gpio_in_sync & ~prev_p1 & rise_en;
      fall = ~gpio_in_sync & prev_p1 & fall_en;
    end
    case (adr)
      IRQ_SYNC:   rdata = gpio_in_sync;
      IRQ_RISE:   rdata = rise_en;
      IRQ_FALL:   rdata = fall_en;
      IRQ_STATUS: rdata = status;
      IRQ_MASK:   rdata = mask;
      default:    rdata = '0;
    endcase
  end

  // Edge-capture stage: prev, arming, sticky status (set wins over W1C), irq
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      prev_p1 <= '0;
      arm_cnt <= ARM_INIT;
      status  <= '0;
      irq     <= 1'b0;
    end else begin
      prev_p1 <= gpio_in_sync;
      if (arm_cnt != '0) arm_cnt <= arm_cnt - 1'b1;
      status  <= (status & ~w1c) | rise | fall;
      irq     <= |(status & mask);
    end
  end

  // Bus stage: one wait state per access, register writes and read data
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      mask     <= '0;
    end else begin
      wb_ack_o <= access;
      wb_dat_o <= (access & ~wb_we_i) ? rdata : '0;
      if (wr) begin
        case (adr)
          IRQ_RISE: rise_en <= (rise_en & ~bmask) | (wb_dat_i & bmask);
          IRQ_FALL: fall_en <= (fall_en & ~bmask) | (wb_dat_i & bmask);
          IRQ_MASK: mask    <= (mask & ~bmask) | (wb_dat_i & bmask);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio32_edge_irq_wb.sv
// Directed bench for gpio32_edge_irq_wb: arming, edge capture, W1C, masking,
// byte lanes, unmapped offsets and reset during an access.
module tb_gpio32_edge_irq_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dat_i, adr, pad, dat_o, sync_out;
  logic [3:0]  sel;
  logic        cyc, stb, we, ack, irq;

  int checks   = 0;
  int failures = 0;

  localparam logic [7:0] A_SYNC = 8'h00, A_RISE = 8'h04, A_FALL = 8'h08,
                         A_STAT = 8'h0c, A_MASK = 8'h10, A_NONE = 8'h20;

  gpio32_edge_irq_wb dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wb_dat_i     (dat_i),
    .wb_adr_i     (adr),
    .wb_sel_i     (sel),
    .wb_cyc_i     (cyc),
    .wb_stb_i     (stb),
    .wb_we_i      (we),
    .wb_dat_o     (dat_o),
    .wb_ack_o     (ack),
    .pad_in       (pad),
    .gpio_in_sync (sync_out),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    adr = {24'h0, a}; dat_i = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    chk("wr_ack_idle", 32'(ack), 32'h0);
    tick();
    chk("wr_ack", 32'(ack), 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    chk("wr_ack_drop", 32'(ack), 32'h0);
  endtask

  task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
    adr = {24'h0, a}; sel = 4'hf; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    chk("rd_ack_idle", 32'(ack), 32'h0);
    tick();
    chk("rd_ack", 32'(ack), 32'h1);
    d = dat_o;
    cyc = 1'b0; stb = 1'b0;
    tick();
    chk("rd_ack_drop", 32'(ack), 32'h0);
  endtask

  logic [31:0] rd;

  initial begin
    rst = 1'b1; pad = 32'hffff_ffff; dat_i = '0; adr = '0; sel = '0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;

    // Reset state with pads already high
    repeat (3) tick();
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_sync", sync_out, 32'h0);
    chk("rst_dato", dat_o, 32'h0);

    // Test 1: enable everything right after release; arming must hide the 0->1
    rst = 1'b0;
    wb_write(A_RISE, 32'hffff_ffff, 4'hf);
    chk("t1_sync", sync_out, 32'hffff_ffff);
    wb_write(A_MASK, 32'hffff_ffff, 4'hf);
    for (int i = 0; i < 20; i++) chk("t1_irq_quiet", 32'(irq), 32'h0);
    repeat (20) tick();
    chk("t1_irq", 32'(irq), 32'h0);
    wb_read(A_STAT, rd);
    chk("t1_status", rd, 32'h0);

    // Test 2: single rising edge on bit 0
    wb_write(A_RISE, 32'h0, 4'hf);
    pad = 32'h0;
    wb_write(A_MASK, 32'h1, 4'hf);
    wb_write(A_RISE, 32'h1, 4'hf);
    repeat (4) tick();
    wb_read(A_STAT, rd);
    chk("t2_status_pre", rd, 32'h0);
    pad[0] = 1'b1;
    tick();
    chk("t2_sync_e1", sync_out, 32'h0);
    tick();
    chk("t2_sync_e2", sync_out, 32'h1);
    chk("t2_irq_e2", 32'(irq), 32'h0);
    tick();
    chk("t2_irq_e3", 32'(irq), 32'h0);
    tick();
    chk("t2_irq_e4", 32'(irq), 32'h1);
    wb_read(A_STAT, rd);
    chk("t2_status", rd, 32'h1);

    // Test 3: W1C colliding with a new edge; set wins
    pad[0] = 1'b0;
    repeat (4) tick();
    chk("t3_irq_hold", 32'(irq), 32'h1);
    pad[0] = 1'b1;
    tick();
    tick();
    wb_write(A_STAT, 32'h1, 4'hf);
    chk("t3_irq_setwin", 32'(irq), 32'h1);
    wb_read(A_STAT, rd);
    chk("t3_status_setwin", rd, 32'h1);
    wb_write(A_STAT, 32'h1, 4'hf);
    chk("t3_irq_clr", 32'(irq), 32'h0);
    wb_read(A_STAT, rd);
    chk("t3_status_clr", rd, 32'h0);

    // Test 4: falling edge on bit 31, masked, then unmasked
    wb_write(A_FALL, 32'h8000_0000, 4'hf);
    wb_write(A_MASK, 32'h0, 4'hf);
    pad[31] = 1'b1;
    repeat (4) tick();
    pad[31] = 1'b0;
    repeat (4) tick();
    wb_read(A_STAT, rd);
    chk("t4_status", rd, 32'h8000_0000);
    chk("t4_irq_masked", 32'(irq), 32'h0);
    wb_write(A_MASK, 32'h8000_0000, 4'hf);
    chk("t4_irq", 32'(irq), 32'h1);

    // Test 5: byte-lane write from reset
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("t5_irq_rst", 32'(irq), 32'h0);
    wb_write(A_RISE, 32'ha5a5_a5a5, 4'b0010);
    wb_read(A_RISE, rd);
    chk("t5_rise", rd, 32'h0000_a500);
    wb_write(A_FALL, 32'h1234_5678, 4'b1001);
    wb_read(A_FALL, rd);
    chk("t5_fall", rd, 32'h1200_0078);

    // Test 6: unmapped offset, read-only SYNC, reset during an access
    wb_write(A_NONE, 32'hdead_beef, 4'hf);
    wb_read(A_NONE, rd);
    chk("t6_unmapped", rd, 32'h0);
    pad = 32'h0000_00c3;
    repeat (3) tick();
    wb_write(A_SYNC, 32'hffff_ffff, 4'hf);
    wb_read(A_SYNC, rd);
    chk("t6_sync_ro", rd, 32'h0000_00c3);
    wb_write(A_MASK, 32'h0000_ffff, 4'hf);
    pad = 32'h0;
    adr = {24'h0, A_MASK}; sel = 4'hf; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    rst = 1'b1;
    tick();
    chk("t6_ack_rst", 32'(ack), 32'h0);
    chk("t6_dato_rst", dat_o, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    tick();
    rst = 1'b0;
    chk("t6_ack_after", 32'(ack), 32'h0);
    wb_read(A_RISE, rd);
    chk("t6_rise0", rd, 32'h0);
    wb_read(A_FALL, rd);
    chk("t6_fall0", rd, 32'h0);
    wb_read(A_STAT, rd);
    chk("t6_stat0", rd, 32'h0);
    wb_read(A_MASK, rd);
    chk("t6_mask0", rd, 32'h0);
    wb_read(A_SYNC, rd);
    chk("t6_sync0", rd, 32'h0);
    chk("t6_irq0", 32'(irq), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
